// File: rtl/cbfp_mod0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cbfp_mod0
//  Description : Stage-0 convergent block floating point normaliser. Finds the
//                smallest redundant-sign-bit count over each block of
//                BLK_CYC input cycles, left-shifts every sample of the block
//                by it and keeps the top OUT_WIDTH bits. The shift leaves as
//                blk_idx, aligned with the scaled data.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbfp_mod0 #(
    parameter int IN_WIDTH  = 23,
    parameter int OUT_WIDTH = 11,
    parameter int DEPTH     = 16,
    parameter int BLK_CYC   = 2,
    parameter int FRAME_CYC = 16,
    parameter int IDX_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        alert_CBFP,
    input  logic signed [IN_WIDTH-1:0]  din_R_add  [0:DEPTH-1],
    input  logic signed [IN_WIDTH-1:0]  din_Q_add  [0:DEPTH-1],
    input  logic signed [IN_WIDTH-1:0]  din_R_sub  [0:DEPTH-1],
    input  logic signed [IN_WIDTH-1:0]  din_Q_sub  [0:DEPTH-1],
    output logic signed [OUT_WIDTH-1:0] dout_R_add [0:DEPTH-1],
    output logic signed [OUT_WIDTH-1:0] dout_Q_add [0:DEPTH-1],
    output logic signed [OUT_WIDTH-1:0] dout_R_sub [0:DEPTH-1],
    output logic signed [OUT_WIDTH-1:0] dout_Q_sub [0:DEPTH-1],
    output logic [IDX_WIDTH-1:0]        blk_idx,
    output logic                        valid_out,
    output logic                        alert_mod10
);

    localparam int c_LANES    = 4 * DEPTH;
    localparam int c_BUS_W    = c_LANES * IN_WIDTH;
    localparam int c_OBUS_W   = c_LANES * OUT_WIDTH;
    localparam int c_CNT_W    = $clog2(FRAME_CYC);
    localparam int c_TRUNC    = IN_WIDTH - OUT_WIDTH;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(FRAME_CYC - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Redundant sign bits: leading bits equal to the MSB, not counting the MSB.
    function automatic logic [IDX_WIDTH-1:0] f_lz(input logic [IN_WIDTH-1:0] x);
        logic [IDX_WIDTH-1:0] n;
        logic                 run;
        n   = '0;
        run = 1'b1;
        for (int b = IN_WIDTH - 2; b >= 0; b--) begin
            if (run && (x[b] == x[IN_WIDTH-1])) begin
                n = n + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    logic [c_BUS_W-1:0]  w_in_bus;
    logic [c_OBUS_W-1:0] w_out_bus;
    logic [c_OBUS_W-1:0] r_out_bus;

    // Flatten the four lane arrays into one bus; lane order R_add, Q_add, R_sub, Q_sub.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lanes
        assign w_in_bus[(0*DEPTH+gi)*IN_WIDTH +: IN_WIDTH] = din_R_add[gi];
        assign w_in_bus[(1*DEPTH+gi)*IN_WIDTH +: IN_WIDTH] = din_Q_add[gi];
        assign w_in_bus[(2*DEPTH+gi)*IN_WIDTH +: IN_WIDTH] = din_R_sub[gi];
        assign w_in_bus[(3*DEPTH+gi)*IN_WIDTH +: IN_WIDTH] = din_Q_sub[gi];
        assign dout_R_add[gi] = r_out_bus[(0*DEPTH+gi)*OUT_WIDTH +: OUT_WIDTH];
        assign dout_Q_add[gi] = r_out_bus[(1*DEPTH+gi)*OUT_WIDTH +: OUT_WIDTH];
        assign dout_R_sub[gi] = r_out_bus[(2*DEPTH+gi)*OUT_WIDTH +: OUT_WIDTH];
        assign dout_Q_sub[gi] = r_out_bus[(3*DEPTH+gi)*OUT_WIDTH +: OUT_WIDTH];
    end

    // ---------------- frame counter ----------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_in_idx;
    logic               w_in_valid;
    logic               w_in_first;
    logic               w_blk_first;
    logic               w_blk_last;

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Idle waits for alert (that cycle is input cycle 0); busy ignores alerts
    // and returns to idle after the last cycle so a new frame can follow directly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_valid  = 1'b0;
        w_in_first  = 1'b0;
        w_in_idx    = '0;
        case (r_state)
            S_IDLE: begin
                if (alert_CBFP) begin
                    w_in_valid  = 1'b1;
                    w_in_first  = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = c_CNT_W'(1);
                end
            end
            S_BUSY: begin
                w_in_valid = 1'b1;
                w_in_idx   = r_cnt;
                if (r_cnt == c_LAST_CNT) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_blk_first = ((32'(w_in_idx) % BLK_CYC) == 0);
    assign w_blk_last  = ((32'(w_in_idx) % BLK_CYC) == BLK_CYC - 1);

    // ---------------- exponent path ----------------
    logic [IDX_WIDTH-1:0] w_cmin;
    logic [IDX_WIDTH-1:0] r_cmin;
    logic                 r_c_valid;
    logic                 r_c_bfirst;
    logic                 r_c_blast;
    logic [IDX_WIDTH-1:0] r_acc;
    logic [IDX_WIDTH-1:0] w_acc;
    logic [IDX_WIDTH-1:0] r_bshift;

    // Minimum sign-bit count over all lanes of the current input cycle.
    always_comb begin
        logic [IDX_WIDTH-1:0] v_lz;
        w_cmin = IDX_WIDTH'(IN_WIDTH - 1);
        v_lz   = '0;
        for (int i = 0; i < c_LANES; i++) begin
            v_lz = f_lz(w_in_bus[i*IN_WIDTH +: IN_WIDTH]);
            if (v_lz < w_cmin) begin
                w_cmin = v_lz;
            end
        end
    end

    // Register the cycle minimum with its block-position tags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmin     <= '0;
            r_c_valid  <= 1'b0;
            r_c_bfirst <= 1'b0;
            r_c_blast  <= 1'b0;
        end else begin
            r_cmin     <= w_in_valid ? w_cmin : '0;
            r_c_valid  <= w_in_valid;
            r_c_bfirst <= w_in_valid & w_blk_first;
            r_c_blast  <= w_in_valid & w_blk_last;
        end
    end

    // Running block minimum; restarts on the first cycle of every block.
    assign w_acc = r_c_bfirst ? r_cmin : ((r_cmin < r_acc) ? r_cmin : r_acc);

    // Accumulate, and hand the finished block minimum to the output side.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc    <= '0;
            r_bshift <= '0;
        end else if (r_c_valid) begin
            r_acc <= w_acc;
            if (r_c_blast) begin
                r_bshift <= w_acc;
            end
        end
    end

    // ---------------- data path ----------------
    logic [c_BUS_W-1:0] r_dly_bus   [0:BLK_CYC];
    logic [BLK_CYC:0]   r_dly_valid;
    logic [BLK_CYC:0]   r_dly_first;

    // Hold the samples until their block exponent is known.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= BLK_CYC; i++) begin
                r_dly_bus[i] <= '0;
            end
            r_dly_valid <= '0;
            r_dly_first <= '0;
        end else begin
            r_dly_bus[0] <= w_in_valid ? w_in_bus : '0;
            for (int i = 1; i <= BLK_CYC; i++) begin
                r_dly_bus[i] <= r_dly_bus[i-1];
            end
            r_dly_valid <= {r_dly_valid[BLK_CYC-1:0], w_in_valid};
            r_dly_first <= {r_dly_first[BLK_CYC-1:0], w_in_first};
        end
    end

    // Normalise and keep the top bits; the shift never exceeds the block's
    // redundant sign bits, so no overflow and a plain truncation is a floor.
    always_comb begin
        w_out_bus = '0;
        for (int i = 0; i < c_LANES; i++) begin
            w_out_bus[i*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'((r_dly_bus[BLK_CYC][i*IN_WIDTH +: IN_WIDTH] << r_bshift) >> c_TRUNC);
        end
    end

    // Output register; everything reads zero outside valid cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_bus   <= '0;
            blk_idx     <= '0;
            valid_out   <= 1'b0;
            alert_mod10 <= 1'b0;
        end else begin
            r_out_bus   <= r_dly_valid[BLK_CYC] ? w_out_bus : '0;
            blk_idx     <= r_dly_valid[BLK_CYC] ? r_bshift : '0;
            valid_out   <= r_dly_valid[BLK_CYC];
            alert_mod10 <= r_dly_first[BLK_CYC];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbfp_mod0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cbfp_mod0
//  Description : Scoreboard bench for cbfp_mod0. Expected output cycles are
//                computed from the driven samples and queued; the monitor
//                pops and compares them as the design produces output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cbfp_mod0;

    localparam int M_ALL1  = 0;
    localparam int M_SPIKE = 1;
    localparam int M_STEP  = 2;
    localparam int M_ZERO  = 3;
    localparam int M_NEG1  = 4;
    localparam int M_RAND  = 5;

    typedef struct packed {
        logic [4:0]        idx;
        logic              first;
        logic [31:0]       cyc;
        logic [63:0][10:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic alert_CBFP = 1'b0;
    logic signed [22:0] din_R_add [0:15];
    logic signed [22:0] din_Q_add [0:15];
    logic signed [22:0] din_R_sub [0:15];
    logic signed [22:0] din_Q_sub [0:15];
    logic signed [10:0] dout_R_add [0:15];
    logic signed [10:0] dout_Q_add [0:15];
    logic signed [10:0] dout_R_sub [0:15];
    logic signed [10:0] dout_Q_sub [0:15];
    logic [4:0] blk_idx;
    logic       valid_out;
    logic       alert_mod10;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   run     = 0;
    int   last_run = 0;
    int   n_valid = 0;
    exp_t sbq [$];
    int   alert_cyc [$];
    int   bs [0:1][0:3][0:15];
    exp_t me;

    cbfp_mod0 dut (
        .clk        (clk),
        .rstn       (rstn),
        .alert_CBFP (alert_CBFP),
        .din_R_add  (din_R_add),
        .din_Q_add  (din_Q_add),
        .din_R_sub  (din_R_sub),
        .din_Q_sub  (din_Q_sub),
        .dout_R_add (dout_R_add),
        .dout_Q_add (dout_Q_add),
        .dout_R_sub (dout_R_sub),
        .dout_Q_sub (dout_Q_sub),
        .blk_idx    (blk_idx),
        .valid_out  (valid_out),
        .alert_mod10(alert_mod10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Redundant sign bits from the magnitude range the value fits in.
    function automatic int mlz(input int v);
        int k;
        k = 0;
        if (v >= 0) begin
            while (v >= (1 << k)) k++;
        end else begin
            while (v < -(1 << k)) k++;
        end
        return 22 - k;
    endfunction

    function automatic int rnd23(input int m);
        int v;
        v = int'($urandom);
        v = (v <<< 9) >>> 9;
        return v >>> m;
    endfunction

    function automatic int gen(input int mode, input int blk, input int c,
                               input int g, input int l, input int m);
        case (mode)
            M_ALL1:  return 1;
            M_SPIKE: return (blk != 0) ? rnd23(m) :
                            ((c == 0 && g == 0 && l == 3) ? -4194304 : 4096);
            M_STEP:  return (blk == 0) ? 4096 : ((blk == 1) ? 1 : rnd23(m));
            M_ZERO:  return 0;
            M_NEG1:  return -1;
            default: return rnd23(m);
        endcase
    endfunction

    function automatic longint dsel(input int g, input int l);
        case (g)
            0:       return longint'(dout_R_add[l]);
            1:       return longint'(dout_Q_add[l]);
            2:       return longint'(dout_R_sub[l]);
            default: return longint'(dout_Q_sub[l]);
        endcase
    endfunction

    task automatic drive_cyc(input bit al, input int c);
        alert_CBFP = al;
        for (int l = 0; l < 16; l++) begin
            din_R_add[l] = 23'(bs[c][0][l]);
            din_Q_add[l] = 23'(bs[c][1][l]);
            din_R_sub[l] = 23'(bs[c][2][l]);
            din_Q_sub[l] = 23'(bs[c][3][l]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alert_CBFP = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame of 8 blocks; expectations are queued as each block is driven.
    task automatic drive_frame(input int mode, input int extra, input int abort_at);
        int   m;
        int   mn;
        int   c0;
        int   y;
        exp_t e;
        for (int blk = 0; blk < 8; blk++) begin
            if (abort_at >= 0 && blk * 2 >= abort_at) return;
            m  = $urandom_range(0, 22);
            mn = 22;
            for (int c = 0; c < 2; c++)
                for (int g = 0; g < 4; g++)
                    for (int l = 0; l < 16; l++) begin
                        bs[c][g][l] = gen(mode, blk, c, g, l, m);
                        if (mlz(bs[c][g][l]) < mn) mn = mlz(bs[c][g][l]);
                    end
            c0 = cyc;
            for (int c = 0; c < 2; c++) begin
                e.idx   = 5'(mn);
                e.first = (blk == 0 && c == 0);
                e.cyc   = 32'(c0 + c + 4);
                for (int g = 0; g < 4; g++)
                    for (int l = 0; l < 16; l++) begin
                        y = (bs[c][g][l] <<< mn) >>> 12;
                        e.d[g*16+l] = 11'(y);
                    end
                sbq.push_back(e);
            end
            for (int c = 0; c < 2; c++) begin
                drive_cyc((blk * 2 + c == 0) || (blk * 2 + c == extra), c);
            end
        end
    endtask

    // Output monitor: compare each valid cycle against the queue head.
    always @(negedge clk) begin
        if (!rstn) begin
            run = 0;
        end else if (valid_out) begin
            n_valid++;
            run++;
            if (alert_mod10) alert_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                me = sbq.pop_front();
                check("latency_cycle", cyc, longint'(me.cyc));
                check("blk_idx", blk_idx, me.idx);
                check("alert_mod10", alert_mod10, me.first);
                for (int g = 0; g < 4; g++)
                    for (int l = 0; l < 16; l++)
                        check($sformatf("dout_g%0d_l%0d", g, l), dsel(g, l),
                              longint'($signed(me.d[g*16+l])));
            end
        end else begin
            if (run > 0) last_run = run;
            run = 0;
            check("idle_blk_idx", blk_idx, 0);
            check("idle_alert", alert_mod10, 0);
            check("idle_dout", dsel(0, 0), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int v0;
        for (int l = 0; l < 16; l++) begin
            din_R_add[l] = '0; din_Q_add[l] = '0; din_R_sub[l] = '0; din_Q_sub[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_blk_idx", blk_idx, 0);
        check("rst_alert", alert_mod10, 0);
        check("rst_dout", dsel(3, 15), 0);
        rstn = 1'b1;
        idle(2);

        // Reset in the middle of a frame while output is already flowing.
        drive_frame(M_ALL1, -1, 6);
        check("pre_reset_valid", valid_out, 1);
        rstn = 1'b0;
        #1;
        check("midrst_valid", valid_out, 0);
        check("midrst_blk_idx", blk_idx, 0);
        check("midrst_dout", dsel(0, 0), 0);
        check("midrst_alert", alert_mod10, 0);
        sbq.delete();
        alert_CBFP = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        v0 = n_valid;
        idle(10);
        check("post_reset_no_valid", n_valid - v0, 0);

        // Single frames with gaps.
        drive_frame(M_ALL1, -1, -1);
        idle(8);
        check("all1_run_len", last_run, 16);
        check("drain_all1", sbq.size(), 0);
        drive_frame(M_SPIKE, -1, -1);
        idle(8);
        check("drain_spike", sbq.size(), 0);
        drive_frame(M_STEP, -1, -1);
        idle(8);
        check("drain_step", sbq.size(), 0);
        drive_frame(M_ZERO, -1, -1);
        idle(8);
        drive_frame(M_NEG1, -1, -1);
        idle(8);
        check("drain_zero_neg1", sbq.size(), 0);

        // Stray alert mid-frame, then a seamless second frame.
        drive_frame(M_RAND, 5, -1);
        drive_frame(M_RAND, -1, -1);
        idle(8);
        check("b2b_run_len", last_run, 32);
        check("b2b_alert_count", alert_cyc.size() >= 2, 1);
        if (alert_cyc.size() >= 2)
            check("b2b_alert_gap", alert_cyc[alert_cyc.size()-1] - alert_cyc[alert_cyc.size()-2], 16);
        check("drain_b2b", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
